// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA on the system clock, 7-bit address match,
// byte-wide write sink and read source through a simple parallel port.
//
// state    | meaning
// IDLE     | not addressed; waiting for START
// ADDR     | shifting address + R/W bit
// ADDR_ACK | driving address ACK
// WR_DATA  | receiving a write byte
// WR_ACK   | driving write-data ACK
// RD_DATA  | transmitting a read byte
// RD_ACK   | released; sampling master ACK/NACK
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] rd_data_in,
    output logic [7:0] wr_data_out,
    output logic       wr_valid_out,
    output logic       rd_req_out,
    output logic       busy_out
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    state_t     state, state_nxt;
    logic       scl_s0, scl_s1, scl_s2;
    logic       sda_s0, sda_s1, sda_s2;
    logic       drv_d1, drv_d2, drv_d3;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       byte_full, byte_full_nxt;
    logic [7:0] shift, shift_nxt;
    logic       rw, rw_nxt;
    logic       sda_nxt;
    logic [7:0] wr_data_nxt;
    logic       wr_valid_nxt, rd_req_nxt, busy_nxt;

    logic scl_rise, scl_fall, drv_hold, start_det, stop_det;

    assign scl_rise = scl_s1 & ~scl_s2;
    assign scl_fall = ~scl_s1 & scl_s2;
    // Our own drive reaches the synced line three cycles late; hold off START/STOP
    // decode until every low we caused has drained out of the pipeline.
    assign drv_hold  = ~sda_out | ~drv_d1 | ~drv_d2 | ~drv_d3;
    assign start_det = scl_s1 & scl_s2 & sda_s2 & ~sda_s1 & ~drv_hold;
    assign stop_det  = scl_s1 & scl_s2 & ~sda_s2 & sda_s1 & ~drv_hold;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            scl_s0       <= 1'b1;
            scl_s1       <= 1'b1;
            scl_s2       <= 1'b1;
            sda_s0       <= 1'b1;
            sda_s1       <= 1'b1;
            sda_s2       <= 1'b1;
            drv_d1       <= 1'b1;
            drv_d2       <= 1'b1;
            drv_d3       <= 1'b1;
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            byte_full    <= 1'b0;
            shift        <= 8'h00;
            rw           <= 1'b0;
            sda_out      <= 1'b1;
            wr_data_out  <= 8'h00;
            wr_valid_out <= 1'b0;
            rd_req_out   <= 1'b0;
            busy_out     <= 1'b0;
        end else begin
            scl_s0       <= scl_in;
            scl_s1       <= scl_s0;
            scl_s2       <= scl_s1;
            sda_s0       <= sda_in & sda_out;
            sda_s1       <= sda_s0;
            sda_s2       <= sda_s1;
            drv_d1       <= sda_out;
            drv_d2       <= drv_d1;
            drv_d3       <= drv_d2;
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            byte_full    <= byte_full_nxt;
            shift        <= shift_nxt;
            rw           <= rw_nxt;
            sda_out      <= sda_nxt;
            wr_data_out  <= wr_data_nxt;
            wr_valid_out <= wr_valid_nxt;
            rd_req_out   <= rd_req_nxt;
            busy_out     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        byte_full_nxt = byte_full;
        shift_nxt     = shift;
        rw_nxt        = rw;
        sda_nxt       = sda_out;
        wr_data_nxt   = wr_data_out;
        wr_valid_nxt  = 1'b0;
        rd_req_nxt    = 1'b0;
        busy_nxt      = busy_out;

        if (start_det) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd0;
            byte_full_nxt = 1'b0;
            sda_nxt       = 1'b1;
        end else if (stop_det) begin
            state_nxt = IDLE;
            sda_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt = {shift[6:0], sda_s1};
                        if (bit_cnt == 3'd7) byte_full_nxt = 1'b1;
                        else                 bit_cnt_nxt   = bit_cnt + 3'd1;
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                        if (shift[7:1] == SLAVE_ADDR) begin
                            rw_nxt    = shift[0];
                            state_nxt = ADDR_ACK;
                            sda_nxt   = 1'b0;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt   = 3'd0;
                        byte_full_nxt = 1'b0;
                        if (rw) begin
                            shift_nxt  = rd_data_in;
                            rd_req_nxt = 1'b1;
                            sda_nxt    = rd_data_in[7];
                            state_nxt  = RD_DATA;
                        end else begin
                            sda_nxt   = 1'b1;
                            state_nxt = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt = {shift[6:0], sda_s1};
                        if (bit_cnt == 3'd7) begin
                            byte_full_nxt = 1'b1;
                            wr_data_nxt   = {shift[6:0], sda_s1};
                            wr_valid_nxt  = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end else if (scl_fall && byte_full) begin
                        sda_nxt       = 1'b0;
                        byte_full_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                        state_nxt     = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt   = 1'b1;
                        state_nxt = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_nxt       = 1'b1;
                            byte_full_nxt = 1'b0;
                            state_nxt     = RD_ACK;
                        end else begin
                            shift_nxt   = {shift[6:0], 1'b0};
                            sda_nxt     = shift[6];
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s1) begin
                            state_nxt = IDLE;
                            sda_nxt   = 1'b1;
                            busy_nxt  = 1'b0;
                        end else begin
                            byte_full_nxt = 1'b1;
                        end
                    end else if (scl_fall && byte_full) begin
                        shift_nxt     = rd_data_in;
                        rd_req_nxt    = 1'b1;
                        sda_nxt       = rd_data_in[7];
                        bit_cnt_nxt   = 3'd0;
                        byte_full_nxt = 1'b0;
                        state_nxt     = RD_DATA;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master driver, transaction-level model, and a
// scoreboard monitor that matches every parallel-port pulse against expectations.
module tb_i2c_slave;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic       sda_out;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] wr_data_out;
    logic       wr_valid_out, rd_req_out, busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];

    localparam logic [6:0] ADDR = 7'h50;

    i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .scl_in      (scl),
        .sda_in      (sda),
        .sda_out     (sda_out),
        .rd_data_in  (rd_data),
        .wr_data_out (wr_data_out),
        .wr_valid_out(wr_valid_out),
        .rd_req_out  (rd_req_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // One SCL period: 8 cycles low, 8 high; the master sees the wired-AND line.
    task automatic bus_bit(input logic b, output logic line);
        sda = b;
        tick(4);
        scl = 1'b1;
        tick(4);
        line = sda & sda_out;
        tick(4);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic bus_start();
        sda = 1'b1;
        tick(4);
        scl = 1'b1;
        tick(8);
        sda = 1'b0;
        tick(8);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic bus_stop();
        sda = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(8);
        sda = 1'b1;
        tick(8);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic l;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], l);
        bus_bit(1'b1, l);
        check(name, 32'(l), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic [7:0] exp_b, input logic [7:0] next_rd,
                             input logic nack, input string name);
        logic [7:0] got;
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, l);
            got[i] = l;
            if (i == 7) rd_data = next_rd;
        end
        check(name, 32'(got), 32'(exp_b));
        bus_bit(nack, l);
    endtask

    // Scoreboard monitor: every port pulse must match the next model expectation.
    logic prev_valid = 1'b0;
    logic prev_req   = 1'b0;
    always @(negedge clk_in) begin
        if (!reset_in) begin
            if (wr_valid_out) begin
                check("wr_valid_width", 32'(prev_valid), 32'(0));
                if (exp_wr.size() == 0) check("unexpected_wr_valid", 32'(wr_data_out), 32'h100);
                else check("wr_data", 32'(wr_data_out), 32'(exp_wr.pop_front()));
            end
            if (rd_req_out) begin
                check("rd_req_width", 32'(prev_req), 32'(0));
                if (exp_rd.size() == 0) check("unexpected_rd_req", 32'(rd_data), 32'h100);
                else check("rd_consumed", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
        end
        prev_valid <= wr_valid_out;
        prev_req   <= rd_req_out;
    end

    function automatic logic addr_acks(input logic [7:0] addr_byte);
        return addr_byte[7:1] == ADDR;
    endfunction

    initial begin
        logic l;
        logic [7:0] keep;

        tick(3);
        reset_in = 1'b0;
        tick(2);
        check("rst_sda", 32'(sda_out), 32'(1));
        check("rst_wr_data", 32'(wr_data_out), 32'(0));
        check("rst_busy", 32'(busy_out), 32'(0));
        check("rst_wr_valid", 32'(wr_valid_out), 32'(0));
        check("rst_rd_req", 32'(rd_req_out), 32'(0));

        // Single-byte write with STOP-to-busy latency
        bus_start();
        write_byte(8'hA0, 1'b0, "wr_addr_ack");
        check("wr_busy", 32'(busy_out), 32'(1));
        exp_wr.push_back(8'hA5);
        write_byte(8'hA5, 1'b0, "wr_data_ack");
        check("wr_data_a5", 32'(wr_data_out), 32'hA5);
        sda = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(8);
        sda = 1'b1;
        tick(2);
        check("busy_before_stop_latency", 32'(busy_out), 32'(1));
        tick(1);
        check("busy_after_stop", 32'(busy_out), 32'(0));
        tick(5);

        // Address mismatch
        bus_start();
        write_byte(8'hA2, 1'b1, "mismatch_nack");
        check("mismatch_busy", 32'(busy_out), 32'(0));
        bus_stop();

        // Two-byte read
        rd_data = 8'h3C;
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'hC3);
        bus_start();
        write_byte(8'hA1, 1'b0, "rd_addr_ack");
        read_byte(8'h3C, 8'hC3, 1'b0, "rd_byte0");
        read_byte(8'hC3, 8'h00, 1'b1, "rd_byte1");
        check("rd_nack_idle", 32'(busy_out), 32'(0));
        bus_stop();

        // Repeated START from write into read
        bus_start();
        write_byte(8'hA0, 1'b0, "sr_wr_addr_ack");
        exp_wr.push_back(8'h11);
        write_byte(8'h11, 1'b0, "sr_wr_data_ack");
        check("sr_wr_data", 32'(wr_data_out), 32'h11);
        rd_data = 8'h77;
        exp_rd.push_back(8'h77);
        bus_start();
        check("sr_busy_held", 32'(busy_out), 32'(1));
        write_byte(8'hA1, 1'b0, "sr_rd_addr_ack");
        check("sr_rd_busy", 32'(busy_out), 32'(1));
        read_byte(8'h77, 8'h00, 1'b1, "sr_rd_byte");
        bus_stop();

        // STOP after four data bits
        bus_start();
        write_byte(8'hA0, 1'b0, "midstop_addr_ack");
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), l);
        bus_stop();
        tick(4);
        check("midstop_wr_data", 32'(wr_data_out), 32'h11);
        check("midstop_busy", 32'(busy_out), 32'(0));

        // Reset while the target drives a 0 data bit
        rd_data = 8'h00;
        exp_rd.push_back(8'h00);
        bus_start();
        write_byte(8'hA1, 1'b0, "rstrd_addr_ack");
        bus_bit(1'b1, l);
        check("rstrd_bit7", 32'(l), 32'(0));
        tick(2);
        check("rstrd_driving", 32'(sda_out), 32'(0));
        reset_in = 1'b1;
        tick(1);
        reset_in = 1'b0;
        check("rstrd_sda", 32'(sda_out), 32'(1));
        check("rstrd_busy", 32'(busy_out), 32'(0));
        check("rstrd_wr_data", 32'(wr_data_out), 32'(0));
        check("rstrd_pulses", 32'({wr_valid_out, rd_req_out}), 32'(0));
        bus_start();
        write_byte(8'hA0, 1'b0, "post_rst_addr_ack");
        exp_wr.push_back(8'h5A);
        write_byte(8'h5A, 1'b0, "post_rst_data_ack");
        bus_stop();
        check("post_rst_wr_data", 32'(wr_data_out), 32'h5A);

        // Randomized transactions against the transaction-level model
        keep = wr_data_out;
        for (int t = 0; t < 8; t++) begin
            logic [7:0] ab;
            logic [7:0] vals[4];
            int nb;
            logic hit;
            ab[7:1] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
            ab[0]   = 1'($urandom_range(0, 1));
            nb      = $urandom_range(1, 3);
            hit     = addr_acks(ab);
            for (int k = 0; k < 4; k++) vals[k] = 8'($urandom);
            if (ab[0]) begin
                rd_data = vals[0];
                if (hit) for (int k = 0; k < nb; k++) exp_rd.push_back(vals[k]);
                bus_start();
                write_byte(ab, ~hit, "rnd_rd_addr");
                if (hit) begin
                    for (int k = 0; k < nb; k++)
                        read_byte(vals[k], vals[k+1], (k == nb - 1), "rnd_rd_byte");
                    check("rnd_rd_done", 32'(busy_out), 32'(0));
                end
                bus_stop();
            end else begin
                bus_start();
                write_byte(ab, ~hit, "rnd_wr_addr");
                for (int k = 0; k < nb; k++) begin
                    if (hit) begin
                        exp_wr.push_back(vals[k]);
                        keep = vals[k];
                    end
                    write_byte(vals[k], ~hit, "rnd_wr_ack");
                end
                bus_stop();
                check("rnd_wr_last", 32'(wr_data_out), 32'(keep));
            end
            check("rnd_idle_busy", 32'(busy_out), 32'(0));
        end

        tick(10);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'(0));
        check("rd_queue_drained", 32'(exp_rd.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
